// File: rtl/dtcm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dtcm_pkg
// Brief   : Shared widths, depth helper and access encoding for the DTCM.
// Revision: 1.0 - initial release
// ============================================================================
package dtcm_pkg;

  localparam int DEF_IO_MAP_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH   = 12;

  // Lowest byte-address bit that belongs to the word index.
  localparam int IDX_LSB = 2;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_e;

  function automatic int word_depth(input int addr_width);
    return 1 << (addr_width - IDX_LSB);
  endfunction

endpackage : dtcm_pkg
`default_nettype wire

// File: rtl/dtcm_if.sv
`default_nettype none
// ============================================================================
// Module  : dtcm_if
// Brief   : Load/store bus between the core-side master and the DTCM slave.
// Revision: 1.0 - initial release
// ============================================================================
interface dtcm_if
  import dtcm_pkg::*;
#(
  parameter int DW = DEF_IO_MAP_WIDTH,
  parameter int AW = DEF_ADDR_WIDTH
) ();

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rw;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (
    output addr,
    output wdata,
    output rw,
    input  rdata,
    input  ready
  );

  modport slave (
    input  addr,
    input  wdata,
    input  rw,
    output rdata,
    output ready
  );

endinterface : dtcm_if
`default_nettype wire

// File: rtl/dtcm_ram.sv
`default_nettype none
// ============================================================================
// Module  : dtcm_ram
// Brief   : Inferable single-port synchronous RAM, read-first registered dout.
//           Optional preload when DTCM_INIT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module dtcm_ram
  import dtcm_pkg::*;
#(
  parameter int    DATA_W    = DEF_IO_MAP_WIDTH,
  parameter int    DEPTH     = word_depth(DEF_ADDR_WIDTH),
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    dout <= mem[idx];
  end

  logic w_unused_init;
  assign w_unused_init = (INIT_FILE != "");

`ifdef DTCM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end
`endif

endmodule : dtcm_ram
`default_nettype wire

// File: rtl/dtcm.sv
`default_nettype none
// ============================================================================
// Module  : dtcm
// Brief   : Word-addressed data TCM, one access per clock, 1-cycle read
//           latency, rdata held across writes. Option macro: DTCM_INIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dtcm
  import dtcm_pkg::*;
#(
  parameter int    IO_MAP_WIDTH = DEF_IO_MAP_WIDTH,
  parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter string INIT_FILE    = ""
) (
  input  logic   clk,
  input  logic   rst,
  dtcm_if.slave  bus
);

  localparam int WORD_DEPTH = word_depth(ADDR_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - IDX_LSB;

  logic [IDX_W-1:0]        w_idx;
  logic [IDX_LSB-1:0]      w_unused_byte_off;
  logic                    w_we;
  logic [IO_MAP_WIDTH-1:0] w_dout;
  logic [IO_MAP_WIDTH-1:0] w_rdata;
  logic [IO_MAP_WIDTH-1:0] r_hold;
  logic                    r_sel_ram;
  logic                    r_ready;

  assign w_idx             = bus.addr[ADDR_WIDTH-1:IDX_LSB];
  assign w_unused_byte_off = bus.addr[IDX_LSB-1:0];

  // Gating with the reset level drops a write that coincides with assertion.
  assign w_we = rst && (bus.rw == ACC_WRITE);

  dtcm_ram #(
    .DATA_W    (IO_MAP_WIDTH),
    .DEPTH     (WORD_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (bus.wdata),
    .dout  (w_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready   <= 1'b0;
      r_sel_ram <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_ready   <= 1'b1;
      r_sel_ram <= (bus.rw == ACC_READ);
      r_hold    <= w_rdata;
    end
  end

  // After a write cycle the RAM dout moved, so present the last visible value.
  assign w_rdata = r_sel_ram ? w_dout : r_hold;

  assign bus.rdata = w_rdata;
  assign bus.ready = r_ready;

endmodule : dtcm
`default_nettype wire

// File: tb/tb_dtcm.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtcm
// Brief   : Directed self-checking bench for the dtcm block.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dtcm;
  import dtcm_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  dtcm_if #(.DW(32), .AW(12)) bus ();

  dtcm #(
    .IO_MAP_WIDTH (32),
    .ADDR_WIDTH   (12),
    .INIT_FILE    ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.rw    = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [11:0] a);
    bus.addr  = a;
    bus.wdata = 32'h0;
    bus.rw    = 1'b0;
    cyc();
  endtask

  logic [11:0] ra;
  logic [31:0] rdv;
  logic [31:0] prev;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    bus.addr  = 12'h0;
    bus.wdata = 32'h0;
    bus.rw    = 1'b0;

    cyc();
    cyc();
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_ready", {31'h0, bus.ready}, 32'h0);
    rst = 1'b1;
    cyc();
    chk("ready_after_release", {31'h0, bus.ready}, 32'h1);

    wr(12'h000, 32'hDEADBEEF);
    rd(12'h000);
    chk("rd_0x000", bus.rdata, 32'hDEADBEEF);
    chk("ready_0x000", {31'h0, bus.ready}, 32'h1);
    wr(12'hFFC, 32'hAABBCCDD);
    rd(12'hFFC);
    chk("rd_0xFFC", bus.rdata, 32'hAABBCCDD);

    wr(12'h200, 32'h55555555);
    wr(12'h204, 32'h66666666);
    chk("hold_b2b_writes", bus.rdata, 32'hAABBCCDD);
    rd(12'h200);
    chk("rd_0x200", bus.rdata, 32'h55555555);
    rd(12'h204);
    chk("rd_0x204", bus.rdata, 32'h66666666);

    rd(12'h000);
    chk("rd_0x000_again", bus.rdata, 32'hDEADBEEF);
    wr(12'h100, 32'hABCDEF12);
    chk("hold_during_write", bus.rdata, 32'hDEADBEEF);
    rd(12'h100);
    chk("rd_0x100", bus.rdata, 32'hABCDEF12);

    wr(12'h101, 32'h12345678);
    rd(12'h103);
    chk("alias_0x103", bus.rdata, 32'h12345678);
    rd(12'h100);
    chk("alias_0x100", bus.rdata, 32'h12345678);

    for (int i = 0; i < 5; i++) begin
      ra  = 12'($urandom_range(0, 4095));
      rdv = $urandom;
      wr(ra, rdv);
      rd(ra ^ 12'($urandom_range(0, 3)));
      chk($sformatf("rand_%0d", i), bus.rdata, rdv);
      chk($sformatf("rand_ready_%0d", i), {31'h0, bus.ready}, 32'h1);
    end

    rd(12'h204);
    prev = bus.rdata;
    chk("pre_reset_rdata", prev, 32'h66666666);
    wr(12'h040, 32'hCAFEF00D);
    // Assert reset between edges: outputs must clear without a clock edge.
    rst       = 1'b0;
    bus.addr  = 12'h040;
    bus.wdata = 32'h0BAD0BAD;
    bus.rw    = 1'b1;
    #1;
    chk("async_rst_rdata", bus.rdata, 32'h0);
    chk("async_rst_ready", {31'h0, bus.ready}, 32'h0);
    cyc();
    chk("rst_hold_rdata", bus.rdata, 32'h0);
    rst = 1'b1;
    rd(12'h040);
    chk("persist_0x040", bus.rdata, 32'hCAFEF00D);
    chk("ready_after_pulse", {31'h0, bus.ready}, 32'h1);
    rd(12'hFFC);
    chk("persist_0xFFC", bus.rdata, 32'hAABBCCDD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dtcm
`default_nettype wire
